// File: rtl/led_scan_pkg.sv
// Shared definitions for the LED matrix scan controller: FSM states,
// matrix/row limits and the cycle-counter width helper.
package led_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_e;

   localparam int MAX_ROWS   = 8;
   localparam int NUM_MATRIX = 4;

   // Width needed to count up to the longer of the two phase lengths.
   function automatic int cnt_width(input int dwell, input int blank);
      int m;
      m = (dwell > blank) ? dwell : blank;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/led_rr_pick.sv
// Round-robin picker: finds the first requesting matrix strictly after
// cur_idx (cyclic); wrapped flags that the search went back to or below cur_idx.
module led_rr_pick
   import led_scan_pkg::*;
(
   input  logic [1:0]            cur_idx,
   input  logic [NUM_MATRIX-1:0] req,
   output logic [1:0]            next_idx,
   output logic                  valid,
   output logic                  wrapped
);

   logic [1:0] cand;

   always_comb begin
      next_idx = '0;
      valid    = 1'b0;
      cand     = '0;
      // Walk from the farthest offset down so the nearest requester wins.
      for (int off = NUM_MATRIX; off >= 1; off--) begin
         cand = cur_idx + 2'(off);
         if (req[cand]) begin
            next_idx = cand;
            valid    = 1'b1;
         end
      end
      wrapped = valid && (next_idx <= cur_idx);
   end

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// LED matrix scan controller: round-robin over requesting matrices, with a
// blanking gap before every row so the decoder select never moves while enabled.
module led_matrix_scan_ctrl
   import led_scan_pkg::*;
#(
   parameter int ROWS         = 8,
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            scan_en_i,
   input  logic [3:0]      matrix_req_i,
   output logic [1:0]      sel_2bit_o,
   output logic            decoder_en_o,
   output logic [ROWS-1:0] row_sel_o,
   output logic            frame_done_o
);

   localparam int CW = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

   scan_state_e   state;
   logic [CW-1:0] cnt;
   logic [RW-1:0] row;

   logic [1:0] pick_cur;
   logic [1:0] pick_idx;
   logic       pick_valid;
   logic       pick_wrapped;

   // From IDLE the search starts just after matrix 3, i.e. at matrix 0.
   assign pick_cur = (state == IDLE) ? 2'd3 : sel_2bit_o;

   led_rr_pick u_pick (
      .cur_idx  (pick_cur),
      .req      (matrix_req_i),
      .next_idx (pick_idx),
      .valid    (pick_valid),
      .wrapped  (pick_wrapped)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state        <= IDLE;
         cnt          <= '0;
         row          <= '0;
         sel_2bit_o   <= '0;
         decoder_en_o <= 1'b0;
         row_sel_o    <= '0;
         frame_done_o <= 1'b0;
      end else begin
         frame_done_o <= 1'b0;
         if (state != IDLE && !scan_en_i) begin
            state        <= IDLE;
            cnt          <= '0;
            row          <= '0;
            decoder_en_o <= 1'b0;
            row_sel_o    <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (scan_en_i && pick_valid) begin
                     state      <= BLANK;
                     sel_2bit_o <= pick_idx;
                     row        <= '0;
                     cnt        <= '0;
                  end
               end
               BLANK: begin
                  if (cnt == BLANK_LAST) begin
                     state        <= DRIVE;
                     cnt          <= '0;
                     decoder_en_o <= 1'b1;
                     row_sel_o    <= ROWS'(1) << row;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               DRIVE: begin
                  if (cnt == DWELL_LAST) begin
                     cnt          <= '0;
                     decoder_en_o <= 1'b0;
                     row_sel_o    <= '0;
                     if (row != ROW_LAST) begin
                        row   <= row + 1'b1;
                        state <= BLANK;
                     end else begin
                        // Matrix advance: the only point matrix_req_i is sampled.
                        row <= '0;
                        if (pick_valid) begin
                           state        <= BLANK;
                           sel_2bit_o   <= pick_idx;
                           frame_done_o <= pick_wrapped;
                        end else begin
                           state <= IDLE;
                        end
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Directed bench for led_matrix_scan_ctrl (ROWS=2, DWELL=3, BLANK=1) with a
// scoreboard of expected row drives and frame_done pulse times.
module tb_led_matrix_scan_ctrl;

   localparam int ROWS  = 2;
   localparam int DWELL = 3;
   localparam int BLANK = 1;
   localparam int ROW_P = BLANK + DWELL;
   localparam int W     = 18;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            scan_en = 1'b0;
   logic [3:0]      req = 4'b0000;
   logic [1:0]      sel;
   logic            dec_en;
   logic [ROWS-1:0] row_sel;
   logic            frame_done;

   led_matrix_scan_ctrl #(
      .ROWS         (ROWS),
      .DWELL_CYCLES (DWELL),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .scan_en_i    (scan_en),
      .matrix_req_i (req),
      .sel_2bit_o   (sel),
      .decoder_en_o (dec_en),
      .row_sel_o    (row_sel),
      .frame_done_o (frame_done)
   );

   // clock / reset
   initial forever #5 clk = ~clk;

   int cyc  = 0;
   int base = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // Entry: {run length[17:14], start edge[13:4], sel[3:2], row_sel[1:0]}
   logic [W-1:0] exp_q[$];
   logic [9:0]   fd_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_drive(input int start, input logic [1:0] s, input logic [1:0] r, input int len);
      exp_q.push_back({4'(len), 10'(start), s, r});
   endtask

   // A matrix selected at edge t drives row 0 then row 1, each after a blank gap.
   task automatic push_mat(input int t, input logic [1:0] s);
      push_drive(t + BLANK, s, 2'b01, DWELL);
      push_drive(t + ROW_P + BLANK, s, 2'b10, DWELL);
   endtask

   task automatic goto(input int e);
      while ((cyc - base) < e) @(negedge clk);
   endtask

   // monitor / scoreboard pop
   logic            mon_on = 1'b0;
   logic            prev_en = 1'b0;
   logic [1:0]      prev_sel = '0;
   logic [ROWS-1:0] prev_row = '0;
   int              run = 0;
   int              exp_len = 0;
   logic [W-1:0]    ent;

   always @(negedge clk) begin
      if (mon_on) begin
         check("row_onehot0", $onehot0(row_sel), 1);
         check("en_row_agree", dec_en ? (row_sel != 0) : (row_sel == 0), 1);
         if (dec_en && prev_en) begin
            check("sel_stable", sel, prev_sel);
            check("row_stable", row_sel, prev_row);
         end
         if (frame_done) begin
            check("fd_in_blank", dec_en, 0);
            if (fd_q.size() == 0) check("fd_extra", cyc - base, 'h3FF);
            else check("fd_time", cyc - base, fd_q.pop_front());
         end
         if (dec_en && !prev_en) begin
            check("sel_bbm", sel, prev_sel);
            if (exp_q.size() == 0) begin
               check("drv_extra", cyc - base, 'h3FF);
               exp_len = 0;
            end else begin
               ent = exp_q.pop_front();
               check("drv_start", cyc - base, ent[13:4]);
               check("drv_sel", sel, ent[3:2]);
               check("drv_row", row_sel, ent[1:0]);
               exp_len = ent[17:14];
            end
            run = 1;
         end else if (dec_en) begin
            run++;
         end
         if (!dec_en && prev_en) check("drv_len", run, exp_len);
         prev_en  = dec_en;
         prev_sel = sel;
         prev_row = row_sel;
      end
   end

   // directed steps
   initial begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_sel", sel, 0);
      check("rst_en", dec_en, 0);
      check("rst_row", row_sel, 0);
      check("rst_fd", frame_done, 0);
      rst_n  = 1'b1;
      mon_on = 1'b1;
      @(negedge clk);

      // all four matrices: two full frames
      scan_en = 1'b1;
      req     = 4'b1111;
      base    = cyc + 1;
      for (int f = 0; f < 2; f++)
         for (int m = 0; m < 4; m++) push_mat(32 * f + 8 * m, 2'(m));
      fd_q.push_back(10'd32);
      fd_q.push_back(10'd64);

      // matrices 1 and 3 only
      goto(60);
      req = 4'b1010;
      push_mat(64, 2'd1);
      push_mat(72, 2'd3);
      push_mat(80, 2'd1);
      push_mat(88, 2'd3);
      push_mat(96, 2'd1);
      fd_q.push_back(10'd80);
      fd_q.push_back(10'd96);

      // single matrix 2, then abort during its second DRIVE cycle
      goto(100);
      req = 4'b0100;
      push_mat(104, 2'd2);
      push_mat(112, 2'd2);
      push_mat(120, 2'd2);
      push_drive(129, 2'd2, 2'b01, 2);
      fd_q.push_back(10'd112);
      fd_q.push_back(10'd120);
      fd_q.push_back(10'd128);
      goto(130);
      scan_en = 1'b0;
      goto(131);
      check("abort_en", dec_en, 0);
      check("abort_row", row_sel, 0);

      // restart picks the lowest requester
      goto(135);
      scan_en = 1'b1;
      req     = 4'b0110;
      push_mat(136, 2'd1);
      push_mat(144, 2'd2);
      push_mat(152, 2'd1);
      fd_q.push_back(10'd152);

      // requests withdrawn while matrix 1 is mid-scan
      goto(154);
      req = 4'b0011;
      push_mat(160, 2'd0);
      push_mat(168, 2'd1);
      fd_q.push_back(10'd160);
      goto(170);
      req = 4'b0000;
      goto(185);
      check("idle_en", dec_en, 0);
      check("idle_row", row_sel, 0);
      check("idle_sel_kept", sel, 1);
      check("idle_fd", frame_done, 0);

      // async reset in the middle of DRIVE
      scan_en = 1'b1;
      req     = 4'b1100;
      push_drive(187, 2'd2, 2'b01, 2);
      goto(188);
      check("pre_rst_en", dec_en, 1);
      check("pre_rst_sel", sel, 2);
      #2 rst_n = 1'b0;
      #1;
      check("async_sel", sel, 0);
      check("async_en", dec_en, 0);
      check("async_row", row_sel, 0);
      check("async_fd", frame_done, 0);
      @(negedge clk);
      scan_en = 1'b0;
      rst_n   = 1'b1;
      repeat (3) @(negedge clk);
      check("end_en", dec_en, 0);
      check("drv_q_left", exp_q.size(), 0);
      check("fd_q_left", fd_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
